// File: rtl/prg_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | prg_mem_loader: boot loader that streams bytes into program memory by    |
// | byte lanes, then reads the image back and checks an additive checksum.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prg_mem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH:0]           load_len,
  input  logic                          s_valid,
  input  logic [COL_WIDTH-1:0]          s_data,
  output logic                          s_ready,
  output logic [NB_COL-1:0]             mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   mem_wdata,
  input  logic [NB_COL*COL_WIDTH-1:0]   mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          chk_ok,
  output logic [NB_COL*COL_WIDTH-1:0]   checksum
);
  localparam int DW     = NB_COL * COL_WIDTH;
  localparam int LANE_W = (NB_COL > 1) ? $clog2(NB_COL) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NB_COL - 1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len, len_nxt, len_m1;
  logic [ADDR_WIDTH:0]   word_idx, word_idx_nxt;
  logic [ADDR_WIDTH:0]   vaddr, vaddr_nxt;
  logic [LANE_W-1:0]     lane, lane_nxt;
  logic [DW-1:0]         shadow, shadow_nxt;
  logic [DW-1:0]         write_sum, write_sum_nxt;
  logic [DW-1:0]         read_sum, read_sum_nxt, sum_next;
  logic                  addr_vld, addr_vld_nxt;
  logic                  data_vld, data_vld_nxt;
  logic                  s_ready_nxt, busy_nxt, done_nxt, chk_ok_nxt;
  logic [NB_COL-1:0]     mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DW-1:0]         mem_wdata_nxt, checksum_nxt;

  assign len_m1   = len - {{ADDR_WIDTH{1'b0}}, 1'b1};
  // data_vld marks the cycle in which mem_rdata belongs to an issued read
  assign sum_next = read_sum + (data_vld ? mem_rdata : '0);

  always_comb begin
    state_nxt     = state;
    len_nxt       = len;
    word_idx_nxt  = word_idx;
    vaddr_nxt     = vaddr;
    lane_nxt      = lane;
    shadow_nxt    = shadow;
    write_sum_nxt = write_sum;
    read_sum_nxt  = sum_next;
    addr_vld_nxt  = 1'b0;
    data_vld_nxt  = addr_vld;
    s_ready_nxt   = s_ready;
    mem_we_nxt    = '0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    chk_ok_nxt    = chk_ok;
    checksum_nxt  = checksum;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_nxt       = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          word_idx_nxt  = '0;
          vaddr_nxt     = '0;
          lane_nxt      = '0;
          shadow_nxt    = '0;
          write_sum_nxt = '0;
          read_sum_nxt  = '0;
          chk_ok_nxt    = 1'b0;
          checksum_nxt  = '0;
          if (load_len == '0) begin
            done_nxt   = 1'b1;
            chk_ok_nxt = 1'b1;
          end else begin
            state_nxt   = S_LOAD;
            s_ready_nxt = 1'b1;
            busy_nxt    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (s_valid && s_ready) begin
          mem_we_nxt    = NB_COL'(1) << lane;
          mem_addr_nxt  = word_idx[ADDR_WIDTH-1:0];
          mem_wdata_nxt = {NB_COL{s_data}};
          shadow_nxt[int'(lane)*COL_WIDTH +: COL_WIDTH] = s_data;
          lane_nxt = (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
          if (lane == LAST_LANE) begin
            write_sum_nxt = write_sum + shadow_nxt;
            word_idx_nxt  = word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (word_idx == len_m1) begin
              s_ready_nxt = 1'b0;
              state_nxt   = S_VERIFY;
            end
          end
        end
      end
      S_VERIFY: begin
        mem_addr_nxt = vaddr[ADDR_WIDTH-1:0];
        addr_vld_nxt = 1'b1;
        vaddr_nxt    = vaddr + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (vaddr == len_m1) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // finish once the last issued read has been summed
        if (data_vld && !addr_vld) begin
          state_nxt    = S_IDLE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          chk_ok_nxt   = (sum_next == write_sum);
          checksum_nxt = sum_next;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      word_idx  <= '0;
      vaddr     <= '0;
      lane      <= '0;
      shadow    <= '0;
      write_sum <= '0;
      read_sum  <= '0;
      addr_vld  <= 1'b0;
      data_vld  <= 1'b0;
      s_ready   <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      chk_ok    <= 1'b0;
      checksum  <= '0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      word_idx  <= word_idx_nxt;
      vaddr     <= vaddr_nxt;
      lane      <= lane_nxt;
      shadow    <= shadow_nxt;
      write_sum <= write_sum_nxt;
      read_sum  <= read_sum_nxt;
      addr_vld  <= addr_vld_nxt;
      data_vld  <= data_vld_nxt;
      s_ready   <= s_ready_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      chk_ok    <= chk_ok_nxt;
      checksum  <= checksum_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_prg_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for prg_mem_loader: word-level reference model feeds write/done
// scoreboards; a negedge monitor pops and compares DUT activity.
module tb_prg_mem_loader;
  localparam int AW    = 12;
  localparam int NC    = 4;
  localparam int CW    = 8;
  localparam int DW    = NC * CW;
  localparam int DEPTH = 1 << AW;

  typedef logic [CW-1:0] byte_q_t[$];
  typedef struct packed {
    logic [NC-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } wr_t;
  typedef struct packed {
    logic          ok;
    logic [DW-1:0] sum;
    logic          addr_chk;
    logic [AW-1:0] last_addr;
  } dn_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          s_valid = 1'b0;
  logic [CW-1:0] s_data = '0;
  logic          s_ready, busy, done, chk_ok;
  logic [NC-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, checksum;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [DEPTH];
  bit            flip_bit0 = 1'b0;
  wr_t           wr_q[$];
  dn_t           dn_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;

  always #5 clock = ~clock;

  prg_mem_loader #(.ADDR_WIDTH(AW), .NB_COL(NC), .COL_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .chk_ok(chk_ok), .checksum(checksum)
  );

  // Byte-write-enable memory, 1-cycle read latency, optional read fault on word 1
  initial begin
    logic [DW-1:0] w;
    forever begin
      @(posedge clock);
      if (mem_we != '0) begin
        w = mem[mem_addr];
        for (int l = 0; l < NC; l++)
          if (mem_we[l]) w[l*CW +: CW] = mem_wdata[l*CW +: CW];
        mem[mem_addr] = w;
      end else begin
        mem_rdata <= mem[mem_addr] ^ ((flip_bit0 && mem_addr == AW'(1)) ? DW'(1) : DW'(0));
      end
    end
  end

  // Monitor: a write must follow each accept and only an accept; done pops the result queue
  initial begin
    bit  prev_acc;
    wr_t e;
    dn_t d;
    prev_acc = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write_extra: we=%h addr=%h wdata=%h, none expected", mem_we, mem_addr, mem_wdata);
          end else begin
            e = wr_q.pop_front();
            if ({mem_we, mem_addr, mem_wdata} !== e) begin
              errors++;
              $display("FAIL write: we=%h addr=%h wdata=%h, expected we=%h addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
            end
          end
        end else if (mem_we != '0) begin
          checks++;
          errors++;
          $display("FAIL write_no_accept: we=%h addr=%h, expected we=0", mem_we, mem_addr);
        end
        if (done) begin
          checks++;
          if (dn_q.size() == 0) begin
            errors++;
            $display("FAIL done_extra: done=1 chk_ok=%b checksum=%h, no done expected", chk_ok, checksum);
          end else begin
            d = dn_q.pop_front();
            if (chk_ok !== d.ok || checksum !== d.sum || busy !== 1'b0 ||
                (d.addr_chk && mem_addr !== d.last_addr)) begin
              errors++;
              $display("FAIL done: chk_ok=%b checksum=%h busy=%b addr=%h, expected chk_ok=%b checksum=%h busy=0 addr=%h",
                       chk_ok, checksum, busy, mem_addr, d.ok, d.sum, d.last_addr);
            end
          end
          done_cnt++;
        end
        prev_acc = s_valid && s_ready;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW:0] l);
    start    = 1'b1;
    load_len = l;
    @(posedge clock); #1;
    start    = 1'b0;
    load_len = (AW+1)'($urandom);
  endtask

  task automatic send_stream(input byte_q_t bytes, input int gap_pct);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    while (i < bytes.size()) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = CW'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = bytes[i];
      end
      @(negedge clock);
      acc = s_valid && s_ready;
      @(posedge clock); #1;
      if (acc) i++;
      guard++;
      if (guard > 50 + 30 * bytes.size()) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: accepted %0d of %0d bytes", i, bytes.size());
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n;
    for (n = 0; n < bound; n++) begin
      @(posedge clock); #1;
      if (done_cnt >= target) break;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, target);
    end
  endtask

  task automatic async_reset();
    #($urandom_range(1, 3));
    reset = 1'b1;
    #1;
    check_val("reset_outputs",
              {32'(s_ready), 4'(mem_we), 12'(mem_addr), 1'(busy), 1'(done), 1'(chk_ok), 1'(checksum != '0), 1'(mem_wdata != '0)},
              64'h0);
    wr_q.delete();
    dn_q.delete();
    s_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_val("ready_after_reset", {s_ready, busy}, 64'h0);
  endtask

  // Reference: words are little-endian byte groups; sums are plain modular additions
  task automatic run_image(input logic [AW:0] llen, input byte_q_t bytes, input int gap_pct, input bit flip);
    int            n;
    int            target;
    logic [DW-1:0] words[$];
    logic [DW-1:0] w, ws, rs;
    dn_t           d;
    n  = (int'(llen) > DEPTH) ? DEPTH : int'(llen);
    ws = '0;
    rs = '0;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < NC; l++) w[l*CW +: CW] = bytes[NC*k + l];
      words.push_back(w);
      ws += w;
      rs += w ^ ((flip && k == 1) ? DW'(1) : DW'(0));
    end
    for (int i = 0; i < NC * n; i++)
      wr_q.push_back('{we: NC'(1) << (i % NC), addr: AW'(i / NC), wdata: {NC{bytes[i]}}});
    d.ok = (rs == ws);
    d.sum = rs;
    d.addr_chk = (n > 0);
    d.last_addr = AW'(n - 1);
    dn_q.push_back(d);
    flip_bit0 = flip;
    target = done_cnt + 1;
    pulse_start(llen);
    if (n == 0) check_val("len0_done_next_cycle", {done, busy}, 64'h2);
    else        check_val("busy_after_start", busy, 64'h1);
    send_stream(bytes, gap_pct);
    wait_done(target, n + 50);
    for (int k = 0; k < n; k++)
      if (mem[k] !== words[k]) check_val($sformatf("mem[%0d]", k), mem[k], words[k]);
      else checks++;
    check_val("wr_queue_empty", wr_q.size(), 64'h0);
    check_val("done_queue_empty", dn_q.size(), 64'h0);
    flip_bit0 = 1'b0;
  endtask

  initial begin
    byte_q_t img, bq;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    for (int i = 1; i <= 8; i++) img.push_back(CW'(i * 8'h11));

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_state", {s_ready, mem_we, mem_addr, busy, done, chk_ok, checksum != '0}, 64'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_val("idle_after_release", {s_ready, busy}, 64'h0);

    // back-to-back image
    run_image(13'd2, img, 0, 1'b0);
    check_val("b2b_checksum", {chk_ok, checksum}, {31'h0, 1'b1, 32'hCCAA8866});
    check_val("b2b_mem", {mem[0], mem[1]}, 64'h88776655_44332211 >> 0 == 0 ? 0 : {32'h44332211, 32'h88776655});

    // same image with stream gaps
    run_image(13'd2, img, 50, 1'b0);
    check_val("gap_checksum", {chk_ok, checksum}, {31'h0, 1'b1, 32'hCCAA8866});

    // read-back fault on word 1
    run_image(13'd2, img, 0, 1'b1);
    check_val("fault_chk_ok", chk_ok, 64'h0);

    // zero length, then oversized length clamped to full depth
    bq.delete();
    run_image(13'd0, bq, 0, 1'b0);
    for (int i = 0; i < NC * DEPTH; i++) bq.push_back(CW'($urandom));
    run_image(13'd4097, bq, 0, 1'b0);
    check_val("full_last_addr", mem_addr, 64'hFFF);

    // reset at a random point of the verify phase
    bq.delete();
    for (int i = 0; i < 2 * NC; i++) bq.push_back(CW'($urandom));
    for (int i = 0; i < 2 * NC; i++)
      wr_q.push_back('{we: NC'(1) << (i % NC), addr: AW'(i / NC), wdata: {NC{bq[i]}}});
    pulse_start(13'd2);
    send_stream(bq, 0);
    repeat ($urandom_range(0, 3)) @(posedge clock);
    #1;
    async_reset();

    // reset after three bytes of word 0, then reload one word
    bq.delete();
    bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
    for (int i = 0; i < 3; i++)
      wr_q.push_back('{we: NC'(1) << i, addr: AW'(0), wdata: {NC{bq[i]}}});
    pulse_start(13'd2);
    send_stream(bq, 0);
    async_reset();
    bq.delete();
    bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC); bq.push_back(8'hDD);
    run_image(13'd1, bq, 0, 1'b0);
    check_val("restart_mem0", {chk_ok, mem[0]}, {31'h0, 1'b1, 32'hDDCCBBAA});

    // random images with random gaps
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 6);
      bq.delete();
      for (int i = 0; i < NC * n; i++) bq.push_back(CW'($urandom));
      run_image((AW+1)'(n), bq, 40, t[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
